// File: rtl/dpu_pkg.sv
// dpu_pkg -- definitions shared by the activation drain path.
//   drain_state_e : act_drain controller states
//   INT8_MIN/MAX  : saturation bounds of the packed output bytes
//   SHIFT_W, BYTE_W, WORD_W, BYTES_PER_WORD : requant / packing geometry
package dpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_PACK  = 3'd4,
    ST_EMIT  = 3'd5,
    ST_DONE  = 3'd6
  } drain_state_e;

  localparam int INT8_MIN       = -128;
  localparam int INT8_MAX       = 127;
  localparam int SHIFT_W        = 5;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/act_requant.sv
// act_requant -- combinational round-half-up right shift with int8 saturation.
//   y     : signed DATA_W activation value
//   shift : right-shift amount (0 = pass through, then saturate)
//   q     : saturated int8 result (two's complement byte)
module act_requant
  import dpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0]  y,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [BYTE_W-1:0]  q
);

  // One guard bit so adding the rounding constant cannot overflow.
  logic signed [DATA_W:0] y_ext;
  logic signed [DATA_W:0] rnd;
  logic signed [DATA_W:0] shifted;

  always_comb begin
    y_ext = {y[DATA_W-1], y};
    rnd   = '0;
    if (shift != '0) begin
      rnd = (DATA_W+1)'(1) << (shift - SHIFT_W'(1));
    end
    shifted = (y_ext + rnd) >>> shift;
    if (shifted > (DATA_W+1)'(INT8_MAX)) begin
      q = BYTE_W'(INT8_MAX);
    end else if (shifted < (DATA_W+1)'(INT8_MIN)) begin
      q = BYTE_W'(INT8_MIN);
    end else begin
      q = shifted[BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/act_drain.sv
// act_drain -- drains an accumulator stream through an external LeakyReLU
// unit, requantises each result to int8 and packs four bytes per output word.
//   clk, rst            : clock, synchronous active-high reset
//   start, len, cfg_shift : job start (IDLE only), element count, requant shift
//   in_valid/in_ready/in_data : accumulator input stream
//   relu_valid/relu_x/relu_y/relu_done : LeakyReLU request/response
//   out_valid/out_ready/out_data/out_last : packed int8 word stream
//   busy, done, err     : status (done pulses one cycle, err is sticky)
// Build option: define ACT_DRAIN_TIMEOUT_EN to abort a job whose LeakyReLU
// response takes longer than TMO_CYC cycles (sets err). Otherwise err is 0.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | accepting one accumulator value
// ISSUE | one-cycle relu_valid request
// WAIT  | waiting for relu_done
// PACK  | requantise and place byte into the word
// EMIT  | presenting a word until out_ready
// DONE  | one-cycle done pulse
module act_drain
  import dpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TMO_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     relu_valid,
  output logic [DATA_W-1:0]        relu_x,
  input  logic signed [DATA_W-1:0] relu_y,
  input  logic                     relu_done,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [WORD_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  drain_state_e state, state_nxt;

  logic [LEN_W-1:0]         rem_r;      // elements not yet packed
  logic [SHIFT_W-1:0]       shift_r;
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] y_r;
  logic [WORD_W-1:0]        word_r;
  logic [1:0]               byte_idx;
  logic [BYTE_W-1:0]        q_byte;
  logic                     tmo_expired;

  act_requant #(.DATA_W(DATA_W)) u_requant (
    .y     (y_r),
    .shift (shift_r),
    .q     (q_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    relu_valid = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        relu_valid = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (relu_done)        state_nxt = ST_PACK;
        else if (tmo_expired) state_nxt = ST_DONE;
      end
      ST_PACK: begin
        // rem_r still counts the element being packed here
        if (rem_r == LEN_W'(1) || byte_idx == 2'd3) state_nxt = ST_EMIT;
        else                                         state_nxt = ST_FETCH;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_last  = (rem_r == '0);
        if (out_ready) state_nxt = (rem_r == '0) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r    <= '0;
      shift_r  <= '0;
      x_r      <= '0;
      y_r      <= '0;
      word_r   <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem_r    <= len;
            shift_r  <= cfg_shift;
            word_r   <= '0;
            byte_idx <= '0;
          end
        end
        ST_FETCH: if (in_valid) x_r <= in_data;
        ST_WAIT:  if (relu_done) y_r <= relu_y;
        ST_PACK: begin
          word_r[BYTE_W*byte_idx +: BYTE_W] <= q_byte;
          byte_idx <= byte_idx + 2'd1;
          rem_r    <= rem_r - LEN_W'(1);
        end
        // Clearing after acceptance keeps unused bytes of a short final word 0.
        ST_EMIT: if (out_ready) word_r <= '0;
        default: ;
      endcase
    end
  end

  assign relu_x   = x_r;
  assign out_data = word_r;

`ifdef ACT_DRAIN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_r;
  logic             err_r;

  // Loaded while issuing; reaching zero with no response means WAIT has
  // already lasted TMO_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (state == ST_ISSUE) tmo_r <= TMO_W'(TMO_CYC);
      else if (state == ST_WAIT && tmo_r != '0) tmo_r <= tmo_r - TMO_W'(1);
      if (state == ST_WAIT && !relu_done && tmo_expired) err_r <= 1'b1;
    end
  end

  assign tmo_expired = (tmo_r == '0);
  assign err         = err_r;
`else
  assign tmo_expired = 1'b0;
  assign err         = 1'b0;
`endif

endmodule
